// File: rtl/mul_share_pkg.sv
// Shared types and constants for the Mul1024bit share arbiter.
// The timeout constant is only referenced when MUL1024_SHARE_TIMEOUT_EN is defined.
package mul_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int TMO_DEFAULT = 4096;
    localparam int TMO_CNT_W   = 13;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mul1024_share_arbiter_rr.sv
// Combinational round-robin pick: first set request scanning upward from ptr+1
// modulo NREQ, returned both as one-hot and as an index.
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul1024_share_arbiter.sv
// Shares one Mul1024bit multiplier between NREQ requesters with round-robin grant.
// Define MUL1024_SHARE_TIMEOUT_EN to add a RUN-state watchdog and the oTimeout output.
module mul1024_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 1024
`ifdef MUL1024_SHARE_TIMEOUT_EN
    ,
    parameter int TMO  = TMO_DEFAULT
`endif
) (
    input  logic                     iClk,
    input  logic                     iReset_n,
    input  logic [NREQ-1:0]          iReq,
    input  logic [NREQ*W-1:0]        iX,
    input  logic [NREQ*W-1:0]        iY,
    output logic [NREQ-1:0]          oGnt,
    output logic [NREQ-1:0]          oDone,
    output logic [prod_width(W)-1:0] oZ,
    output logic                     oBusy,
    output logic                     oMulEnable,
    output logic                     oMulLoad,
    output logic [W-1:0]             oMulX,
    output logic [W-1:0]             oMulY,
    input  logic                     iMulDataValid,
    input  logic [prod_width(W)-1:0] iMulZ
`ifdef MUL1024_SHARE_TIMEOUT_EN
    ,
    output logic                     oTimeout
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   ptr;
    logic [NREQ-1:0] gnt_q;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_gnt;
    logic            pick_valid;
    logic            abort;
    logic            grant;
    logic            capture;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req   (iReq),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Abort takes priority over a same-cycle iMulDataValid.
    assign abort   = ((state == LOAD) || (state == RUN)) && !iReq[gidx];
    assign grant   = (state == IDLE) && pick_valid;
    assign capture = (state == RUN) && !abort && iMulDataValid;

`ifdef MUL1024_SHARE_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] tmo_cnt;
    logic                 tmo_hit;

    assign tmo_hit = (state == RUN) && !abort && !iMulDataValid
                     && (tmo_cnt == TMO_CNT_W'(TMO - 1));
`endif

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state    <= IDLE;
            gidx     <= '0;
            gnt_q    <= '0;
            ptr      <= IW'(NREQ - 1);
            oZ       <= '0;
`ifdef MUL1024_SHARE_TIMEOUT_EN
            tmo_cnt  <= '0;
            oTimeout <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (grant) begin
                gidx  <= pick_idx;
                ptr   <= pick_idx;
                gnt_q <= pick_gnt;
            end
            if (capture) begin
                oZ <= iMulZ;
            end
`ifdef MUL1024_SHARE_TIMEOUT_EN
            if (state == LOAD) begin
                tmo_cnt <= '0;
            end else if (state == RUN) begin
                tmo_cnt <= tmo_cnt + TMO_CNT_W'(1);
            end
            if (tmo_hit) begin
                oTimeout <= 1'b1;
            end
`endif
        end
    end

    // Operands go straight through: Mul1024bit latches them on its load.
    always_comb begin
        state_nxt  = state;
        oBusy      = (state != IDLE);
        oMulEnable = 1'b0;
        oMulLoad   = 1'b0;
        oGnt       = '0;
        oDone      = '0;
        oMulX      = '0;
        oMulY      = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                oMulEnable = 1'b1;
                oMulLoad   = 1'b1;
                oGnt       = gnt_q;
                oMulX      = iX[int'(gidx)*W +: W];
                oMulY      = iY[int'(gidx)*W +: W];
                state_nxt  = abort ? IDLE : RUN;
            end
            RUN: begin
                oMulEnable = 1'b1;
                oGnt       = gnt_q;
                oMulX      = iX[int'(gidx)*W +: W];
                oMulY      = iY[int'(gidx)*W +: W];
                if (abort) begin
                    state_nxt = IDLE;
                end else if (iMulDataValid) begin
                    state_nxt = DONE;
                end
`ifdef MUL1024_SHARE_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
`endif
            end
            DONE: begin
                oGnt      = gnt_q;
                oDone     = gnt_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
